// File: rtl/bank_pkg.sv
// Shared constants, width helper and wait-FSM encoding for the bank queue controller.
package bank_pkg;

    localparam int DEPTH_DEF   = 7;
    localparam int TELLERS_DEF = 3;
    localparam int SERVICE_DEF = 3;

    // Bits needed to hold any value 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        if (max_val < 2) return 1;
        return $clog2(max_val + 1);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wait_state_t;

endpackage

// File: rtl/wait_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WW cycles per result.
// The first bit is resolved on the start cycle straight from the input operands,
// so done pulses WW-1 cycles after start and the quotient is stable from then on.
module wait_divider
    import bank_pkg::*;
#(
    parameter int WW = 5,
    parameter int TW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [WW-1:0] dividend,
    input  logic [TW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] quotient
);

    localparam int NW = width_for(WW);

    logic [TW-1:0] rem_q;
    logic [TW-1:0] dsr_q;
    logic [WW-1:0] dvd_q;
    logic [WW-1:0] quo_q;
    logic [NW-1:0] cnt_q;

    logic [TW-1:0] rem_in;
    logic [TW-1:0] dsr_in;
    logic          bit_in;
    logic [TW:0]   trial;
    logic [TW:0]   diff;
    logic          fits;
    logic [TW-1:0] rem_nx;

    // One restoring step; a fresh start bypasses the registers with the new operands.
    always_comb begin
        rem_in = start ? '0 : rem_q;
        dsr_in = start ? divisor : dsr_q;
        bit_in = start ? dividend[WW-1] : dvd_q[WW-1];
        trial  = {rem_in, bit_in};
        diff   = trial - {1'b0, dsr_in};
        fits   = (trial >= {1'b0, dsr_in});
        // Remainder is always below the divisor, so TW bits hold it either way.
        rem_nx = fits ? diff[TW-1:0] : trial[TW-1:0];
    end

    // Iteration control: start wins over abort, abort drops an in-flight division.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt_q <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= (WW > 1);
                done  <= (WW == 1);
                cnt_q <= NW'(WW - 1);
            end else if (abort) begin
                busy <= 1'b0;
            end else if (busy) begin
                cnt_q <= cnt_q - NW'(1);
                if (cnt_q == NW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Datapath shift registers advance only while a division is live.
    always_ff @(posedge clock) begin
        if (start || (busy && !abort)) begin
            rem_q <= rem_nx;
            dsr_q <= dsr_in;
            dvd_q <= (start ? dividend : dvd_q) << 1;
            quo_q <= ((start ? '0 : quo_q) << 1) | WW'(fits);
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/bank_queue_ctrl.sv
// Bank queue controller: photocell synchronisers and edge detectors, saturating
// customer counter with error pulses, and a wait-time FSM around a serial divider.
module bank_queue_ctrl
    import bank_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int MAX_TELLERS  = TELLERS_DEF,
    parameter int SERVICE_TIME = SERVICE_DEF,
    localparam int CW = width_for(DEPTH),
    localparam int TW = width_for(MAX_TELLERS),
    localparam int WW = width_for(SERVICE_TIME * (DEPTH + MAX_TELLERS - 1))
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          phc_in,
    input  logic          phc_out,
    input  logic [TW-1:0] tcount,
    output logic [CW-1:0] pcount,
    output logic [WW-1:0] pwait,
    output logic          pwait_valid,
    output logic          empty_flag,
    output logic          full_flag,
    output logic          overflow_err,
    output logic          underflow_err,
    output logic          no_teller
);

    logic in_sync_p0, in_sync_p1, in_hist_p2;
    logic out_sync_p0, out_sync_p1, out_hist_p2;
    logic in_ev, out_ev;

    // Two-flop synchronisers plus edge history; reset to 1 so a beam held
    // through reset is not mistaken for a new arrival.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_sync_p0  <= 1'b1;
            in_sync_p1  <= 1'b1;
            in_hist_p2  <= 1'b1;
            out_sync_p0 <= 1'b1;
            out_sync_p1 <= 1'b1;
            out_hist_p2 <= 1'b1;
        end else begin
            in_sync_p0  <= phc_in;
            in_sync_p1  <= in_sync_p0;
            in_hist_p2  <= in_sync_p1;
            out_sync_p0 <= phc_out;
            out_sync_p1 <= out_sync_p0;
            out_hist_p2 <= out_sync_p1;
        end
    end

    assign in_ev  = in_sync_p1 & ~in_hist_p2;
    assign out_ev = out_sync_p1 & ~out_hist_p2;

    logic [CW-1:0] pcount_nx;
    logic          ovf_nx, udf_nx;

    // Next count: simultaneous entry and exit cancel with no error at any fill level.
    always_comb begin
        pcount_nx = pcount;
        ovf_nx    = 1'b0;
        udf_nx    = 1'b0;
        case ({in_ev, out_ev})
            2'b10: begin
                if (pcount < CW'(DEPTH)) pcount_nx = pcount + CW'(1);
                else                     ovf_nx    = 1'b1;
            end
            2'b01: begin
                if (pcount != '0) pcount_nx = pcount - CW'(1);
                else              udf_nx    = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter, flags and error pulses all register together.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcount        <= '0;
            empty_flag    <= 1'b1;
            full_flag     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pcount        <= pcount_nx;
            empty_flag    <= (pcount_nx == '0);
            full_flag     <= (pcount_nx == CW'(DEPTH));
            overflow_err  <= ovf_nx;
            underflow_err <= udf_nx;
        end
    end

    logic [TW-1:0] teff;
    logic [WW-1:0] dividend;
    logic          changed, zero_case;
    logic          div_start, div_abort, div_busy, div_done;
    logic [WW-1:0] div_quotient;
    wait_state_t   state;
    logic [CW-1:0] last_p;
    logic [TW-1:0] last_t;

    assign teff      = (tcount > TW'(MAX_TELLERS)) ? TW'(MAX_TELLERS) : tcount;
    assign no_teller = (teff == '0);
    // Rounded-up share per teller: S*(p+t-1)/t; only used when p and t are non-zero.
    assign dividend  = WW'(SERVICE_TIME) * (WW'(pcount) + WW'(teff) - WW'(1));
    assign changed   = (pcount != last_p) || (teff != last_t);
    assign zero_case = (pcount == '0) || no_teller;
    assign div_start = changed && !zero_case;
    assign div_abort = div_busy && changed && zero_case;

    wait_divider #(
        .WW (WW),
        .TW (TW)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (dividend),
        .divisor  (teff),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Wait FSM: any operand change restarts the division at once; the old
    // estimate is held with valid low until a result for current operands lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pwait       <= '0;
            pwait_valid <= 1'b1;
            last_p      <= '0;
            last_t      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (changed) begin
                        last_p <= pcount;
                        last_t <= teff;
                        if (zero_case) begin
                            pwait       <= '0;
                            pwait_valid <= 1'b1;
                        end else begin
                            pwait_valid <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (changed) begin
                        last_p <= pcount;
                        last_t <= teff;
                        if (zero_case) begin
                            pwait       <= '0;
                            pwait_valid <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (div_done) begin
                        pwait       <= div_quotient;
                        pwait_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Self-checking bench for bank_queue_ctrl: directed scenarios with literal
// expectations, then randomized photocell/teller traffic against a queue model.
module tb_bank_queue_ctrl;

    localparam int DEPTH = 7;
    localparam int MAXT  = 3;
    localparam int SERV  = 3;
    localparam int WW    = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       phc_in = 1'b1;
    logic       phc_out = 1'b0;
    logic [1:0] tcount = 2'd2;
    logic [2:0] pcount;
    logic [4:0] pwait;
    logic       pwait_valid, empty_flag, full_flag, overflow_err, underflow_err, no_teller;

    logic [1:0] sat_tcount = 2'd3;
    logic [2:0] sat_pcount;
    logic [4:0] sat_pwait;
    logic       sat_valid, sat_empty, sat_full, sat_ovf, sat_udf, sat_no_teller;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bank_queue_ctrl #(.DEPTH(DEPTH), .MAX_TELLERS(MAXT), .SERVICE_TIME(SERV)) dut (
        .clock(clock), .reset(reset), .phc_in(phc_in), .phc_out(phc_out), .tcount(tcount),
        .pcount(pcount), .pwait(pwait), .pwait_valid(pwait_valid), .empty_flag(empty_flag),
        .full_flag(full_flag), .overflow_err(overflow_err), .underflow_err(underflow_err),
        .no_teller(no_teller)
    );

    // Second instance with two tellers max, driven with tcount=3 to exercise saturation.
    bank_queue_ctrl #(.DEPTH(DEPTH), .MAX_TELLERS(2), .SERVICE_TIME(SERV)) u_sat (
        .clock(clock), .reset(reset), .phc_in(phc_in), .phc_out(phc_out), .tcount(sat_tcount),
        .pcount(sat_pcount), .pwait(sat_pwait), .pwait_valid(sat_valid), .empty_flag(sat_empty),
        .full_flag(sat_full), .overflow_err(sat_ovf), .underflow_err(sat_udf),
        .no_teller(sat_no_teller)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int teff_of(input int t);
        return (t > MAXT) ? MAXT : t;
    endfunction

    function automatic int wait_of(input int p, input int t);
        if (p == 0 || t == 0) return 0;
        return (SERV * (p + t - 1)) / t;
    endfunction

    // Reference model state
    int m_p = 0, m_pwait = 0, m_lp = 0, m_lt = 0, m_cd = 0, m_t = 0;
    bit m_valid = 1'b1, m_ovf = 1'b0, m_udf = 1'b0;
    bit m_pin = 1'b1, m_pout = 1'b1;
    bit d0i = 1'b0, d1i = 1'b0, d0o = 1'b0, d1o = 1'b0;
    bit ai, ao;

    // Model: a pin rise seen at one edge moves the count two edges later; the
    // estimate for new operands appears WW edges after the change is noticed.
    always @(posedge clock) begin
        if (reset) begin
            m_p = 0; m_ovf = 0; m_udf = 0; m_pin = 1; m_pout = 1;
            d0i = 0; d1i = 0; d0o = 0; d1o = 0;
            m_pwait = 0; m_valid = 1; m_lp = 0; m_lt = 0; m_cd = 0;
        end else begin
            m_t = teff_of(int'(tcount));
            if (m_p != m_lp || m_t != m_lt) begin
                m_lp = m_p;
                m_lt = m_t;
                if (m_p == 0 || m_t == 0) begin
                    m_pwait = 0; m_valid = 1; m_cd = 0;
                end else begin
                    m_valid = 0; m_cd = WW;
                end
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_pwait = wait_of(m_lp, m_lt);
                    m_valid = 1;
                end
            end
            ai = d1i; ao = d1o;
            d1i = d0i; d1o = d0o;
            d0i = phc_in & ~m_pin;  m_pin  = phc_in;
            d0o = phc_out & ~m_pout; m_pout = phc_out;
            m_ovf = 0; m_udf = 0;
            if (ai && !ao) begin
                if (m_p < DEPTH) m_p++; else m_ovf = 1;
            end else if (ao && !ai) begin
                if (m_p > 0) m_p--; else m_udf = 1;
            end
        end
        #1;
        chk("pcount", int'(pcount), m_p);
        chk("empty_flag", int'(empty_flag), int'(m_p == 0));
        chk("full_flag", int'(full_flag), int'(m_p == DEPTH));
        chk("overflow_err", int'(overflow_err), int'(m_ovf));
        chk("underflow_err", int'(underflow_err), int'(m_udf));
        chk("pwait", int'(pwait), m_pwait);
        chk("pwait_valid", int'(pwait_valid), int'(m_valid));
        chk("no_teller", int'(no_teller), int'(teff_of(int'(tcount)) == 0));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive a two-cycle beam break on the chosen cells and count error pulses.
    task automatic pulse(input bit a, input bit b, output int ovf_n, output int udf_n);
        ovf_n = 0; udf_n = 0;
        phc_in = a; phc_out = b;
        repeat (2) begin
            @(negedge clock);
            if (overflow_err) ovf_n++;
            if (underflow_err) udf_n++;
        end
        phc_in = 1'b0; phc_out = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (overflow_err) ovf_n++;
            if (underflow_err) udf_n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    int o, u, lat1, lat2, lat3, valid_at, pw_at, hold_bad;

    initial begin
        // Reset with the entry beam held: release must not count a customer.
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("rst_pcount", int'(pcount), 0);
        chk("rst_empty", int'(empty_flag), 1);
        chk("rst_pwait", int'(pwait), 0);
        chk("rst_valid", int'(pwait_valid), 1);
        phc_in = 1'b0;
        tick(3);

        // Entry latency: pin to pcount is three clocks.
        phc_in = 1'b1;
        @(posedge clock); #1; lat1 = int'(pcount);
        @(posedge clock); #1; lat2 = int'(pcount);
        @(posedge clock); #1; lat3 = int'(pcount);
        chk("lat_edge1", lat1, 0);
        chk("lat_edge2", lat2, 0);
        chk("lat_edge3", lat3, 1);
        @(negedge clock);
        phc_in = 1'b0;
        tick(3);
        repeat (3) pulse(1, 0, o, u);
        tick(WW + 3);
        chk("four_pcount", int'(pcount), 4);
        chk("four_pwait", int'(pwait), 7);
        chk("four_valid", int'(pwait_valid), 1);
        chk("sat_four_pwait", int'(sat_pwait), 7);

        // Fill to DEPTH, then one rejected entry and one balanced pair.
        repeat (3) pulse(1, 0, o, u);
        chk("fill_pcount", int'(pcount), 7);
        chk("fill_full", int'(full_flag), 1);
        pulse(1, 0, o, u);
        chk("ovf_pulse_cycles", o, 1);
        chk("ovf_pcount", int'(pcount), 7);
        pulse(1, 1, o, u);
        chk("both_full_err", o + u, 0);
        chk("both_full_pcount", int'(pcount), 7);

        // Drain, then one rejected exit and a balanced pair at empty.
        repeat (7) pulse(0, 1, o, u);
        chk("drain_empty", int'(empty_flag), 1);
        pulse(0, 1, o, u);
        chk("udf_pulse_cycles", u, 1);
        chk("udf_pcount", int'(pcount), 0);
        pulse(1, 1, o, u);
        chk("both_empty_err", o + u, 0);
        chk("both_empty_pcount", int'(pcount), 0);

        // Teller change while a division is running.
        tcount = 2'd1;
        repeat (5) pulse(1, 0, o, u);
        tick(WW + 3);
        chk("abort_pre_pwait", int'(pwait), 15);
        chk("abort_pre_valid", int'(pwait_valid), 1);
        chk("sat_five_pwait", int'(sat_pwait), 9);
        tcount = 2'd2;
        tick(1);
        chk("abort_busy_valid", int'(pwait_valid), 0);
        chk("abort_busy_pwait", int'(pwait), 15);
        tick(1);
        tcount = 2'd3;
        valid_at = -1; pw_at = -1; hold_bad = 0;
        for (int i = 1; i <= WW + 4; i++) begin
            tick(1);
            if (!pwait_valid) begin
                if (pwait != 5'd15) hold_bad++;
            end else if (valid_at < 0) begin
                valid_at = i;
                pw_at = int'(pwait);
            end
        end
        chk("abort_hold_bad", hold_bad, 0);
        chk("abort_latency", valid_at, WW + 1);
        chk("abort_result", pw_at, 7);

        // No tellers, then saturated teller count.
        repeat (2) pulse(0, 1, o, u);
        tcount = 2'd0;
        #1;
        chk("no_teller_flag", int'(no_teller), 1);
        tick(1);
        chk("no_teller_pwait", int'(pwait), 0);
        chk("no_teller_valid", int'(pwait_valid), 1);
        tcount = 2'd3;
        repeat (2) pulse(0, 1, o, u);
        tick(WW + 3);
        chk("one_pwait", int'(pwait), 3);
        chk("sat_pcount", int'(sat_pcount), 1);
        chk("sat_pwait", int'(sat_pwait), 3);
        chk("sat_no_teller", int'(sat_no_teller), 0);

        // Randomized traffic: fill-biased, then drain-biased, with rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, (i < 2000) ? 1 : 4) == 0) phc_in = ~phc_in;
            if ($urandom_range(0, (i < 2000) ? 4 : 1) == 0) phc_out = ~phc_out;
            if ($urandom_range(0, 19) == 0) tcount = 2'($urandom_range(0, 3));
        end
        reset = 1'b0;
        tick(WW + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
